// File: rtl/cdc_xfer_arbiter.sv
// rtl/cdc_xfer_arbiter.sv - round-robin arbiter sharing one pulse-synchronizer crossing
//
// Several requesters share one pulse-synchronizer crossing. The arbiter picks a
// winner in round-robin order and latches the winner's payload. It launches one
// 1-cycle crossing pulse, then holds the payload stable until the return-path
// acknowledge arrives. Only one toggle is ever in flight at a time.
//
// Optional feature: define CDC_XFER_TIMEOUT_EN to compile in the acknowledge
// timeout counter, the FLUSH state and err generation.
//
// Ports:
//   clk, rst    source-domain clock; asynchronous active-high reset
//   req_valid   per-requester request level, held until req_ready
//   req_data    payloads, requester i at [i*DW +: DW]
//   req_ready   one-hot accept strobe (combinational)
//   xfer_pulse  registered 1-cycle launch pulse to the synchronizer d input
//   xfer_data   latched payload, stable from launch until completion
//   xfer_src    index of the granted requester
//   ack_pulse   1-cycle acknowledge from the return synchronizer
//   busy        high whenever the controller is not idle
//   done        1-cycle completion strobe to the owning requester
//   err         1-cycle timeout strobe (constant 0 without the timeout feature)

module cdc_xfer_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DW     = 32,
  parameter int TO_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*DW-1:0]    req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   xfer_pulse,
  output logic [DW-1:0]          xfer_data,
  output logic [$clog2(N_REQ)-1:0] xfer_src,
  input  logic                   ack_pulse,
  output logic                   busy,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err
);

  localparam int SW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

`ifdef CDC_XFER_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, FLUSH} state_t;
  localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);
`else
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;
  // TO_CYC has no role without the timeout feature.
  localparam int unused_to_cyc = TO_CYC;
`endif

  state_t          state, state_nxt;
  logic [SW-1:0]   last;
  logic            grant_any;
  logic [SW-1:0]   grant_idx;
  int              idx;
  logic            ack_done;
  logic            launch;

`ifdef CDC_XFER_TIMEOUT_EN
  logic [15:0]     cnt;
  logic            to_fire;
`endif

  // Round-robin scan starting just after the last owner.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = SW'(idx);
      end
    end
  end

  assign launch    = (state == IDLE) && grant_any;
  assign req_ready = launch ? (ONE << grant_idx) : '0;
  assign ack_done  = (state == WAIT_ACK) && ack_pulse;

`ifdef CDC_XFER_TIMEOUT_EN
  // An ack in the final counted cycle wins over the timeout.
  assign to_fire = (state == WAIT_ACK) && !ack_pulse && (cnt == TO_LAST);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant_any) state_nxt = SEND;
      SEND:     state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (ack_pulse) state_nxt = IDLE;
`ifdef CDC_XFER_TIMEOUT_EN
        else if (cnt == TO_LAST) state_nxt = FLUSH;
`endif
      end
`ifdef CDC_XFER_TIMEOUT_EN
      // Swallow one late ack (or give up waiting) so it cannot complete the
      // next transfer.
      FLUSH:    if (ack_pulse || cnt == TO_LAST) state_nxt = IDLE;
`endif
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      last       <= SW'(N_REQ - 1);
      xfer_pulse <= 1'b0;
      xfer_data  <= '0;
      xfer_src   <= '0;
      done       <= '0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != IDLE);
      xfer_pulse <= launch;
      if (launch) begin
        xfer_data <= req_data[int'(grant_idx)*DW +: DW];
        xfer_src  <= grant_idx;
      end
      done <= ack_done ? (ONE << xfer_src) : '0;
      if (ack_done) last <= xfer_src;
`ifdef CDC_XFER_TIMEOUT_EN
      if (to_fire) last <= xfer_src;
`endif
    end
  end

`ifdef CDC_XFER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= '0;
    end else begin
      err <= to_fire ? (ONE << xfer_src) : '0;
      // Restart on every state change, so WAIT_ACK and FLUSH each count from 0.
      if (state_nxt != state)
        cnt <= '0;
      else if (state == WAIT_ACK || state == FLUSH)
        cnt <= cnt + 16'd1;
    end
  end
`else
  assign err = '0;
`endif

endmodule
